// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: signal bit
// indices, FSM state type and default memory base address.
package mem_pkg;

  localparam int MEM_R_BIT = 1;
  localparam int MEM_W_BIT = 0;

  localparam int MEM_BASE_DEFAULT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word loads/stores with WAIT_CYCLES stall, MEM/WB register.
// Optional address checking and sticky addr_err under `MEM_ADDR_CHECK_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic [1:0]  MEM_Signal_in,
  input  logic [4:0]  dest_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg2_in,
  output logic        freeze,
  output logic        WB_en_WB,
  output logic        MEM_R_EN_WB,
  output logic [4:0]  dest_WB,
  output logic [31:0] ALU_result_WB,
  output logic [31:0] mem_data_WB,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_cnt;
  logic [15:0]   w_cnt_nxt;
  logic          w_done;
  logic          w_req;
  logic          w_store;
  logic          w_load;
  logic          w_err;
  logic          w_we;
  logic [AW-1:0] w_word_addr;
  logic [31:0]   w_rdata;

  logic          r_wb_en;
  logic          r_mem_r_en;
  logic [4:0]    r_dest;
  logic [31:0]   r_alu_result;
  logic [31:0]   r_mem_data;

  // Store wins when both request bits are set.
  assign w_req       = |MEM_Signal_in;
  assign w_store     = MEM_Signal_in[MEM_W_BIT];
  assign w_load      = MEM_Signal_in[MEM_R_BIT] & ~w_store;
  assign w_word_addr = AW'((ALU_result_in - 32'(MEM_BASE)) >> 2);

`ifdef MEM_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_err = w_req & ((ALU_result_in < 32'(MEM_BASE)) |
                          (ALU_result_in >= 32'(MEM_BASE + 4 * DEPTH)) |
                          (ALU_result_in[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_err <= 1'b0;
    end else if (w_done && w_err) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_err    = 1'b0;
  assign addr_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_req || WAIT_CYCLES == 0) begin
          w_done = 1'b1;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 16'd1;
        end
      end
      WAIT: begin
        if (r_cnt == 16'(WAIT_CYCLES)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reset gating makes freeze and any pending store vanish the moment rst falls.
  assign freeze = rst & ~w_done;
  assign w_we   = rst & w_done & w_store & ~w_err;

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_word_addr),
    .i_wdata (reg2_in),
    .o_rdata (w_rdata)
  );

  // MEM/WB register: capture on completion, bubble while frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_dest       <= 5'd0;
      r_alu_result <= 32'd0;
      r_mem_data   <= 32'd0;
    end else if (w_done) begin
      r_wb_en      <= WB_en_in;
      r_mem_r_en   <= w_load;
      r_dest       <= dest_in;
      r_alu_result <= ALU_result_in;
      if (w_load) begin
        r_mem_data <= w_err ? 32'd0 : w_rdata;
      end
    end else begin
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
    end
  end

  assign WB_en_WB      = r_wb_en;
  assign MEM_R_EN_WB   = r_mem_r_en;
  assign dest_WB       = r_dest;
  assign ALU_result_WB = r_alu_result;
  assign mem_data_WB   = r_mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset/corner sequences,
// randomized ops against a word-array reference model, and a WAIT_CYCLES=0 instance.
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int BASE  = 1024;
  localparam int W     = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        WB_en_in = 1'b0;
  logic [1:0]  MEM_Signal_in = 2'b00;
  logic [4:0]  dest_in = 5'd0;
  logic [31:0] ALU_result_in = 32'd0;
  logic [31:0] reg2_in = 32'd0;
  logic        freeze, WB_en_WB, MEM_R_EN_WB, addr_err;
  logic [4:0]  dest_WB;
  logic [31:0] ALU_result_WB, mem_data_WB;

  logic        z_WB_en_in = 1'b0;
  logic [1:0]  z_MEM_Signal_in = 2'b00;
  logic [4:0]  z_dest_in = 5'd0;
  logic [31:0] z_ALU_result_in = 32'd0;
  logic [31:0] z_reg2_in = 32'd0;
  logic        z_freeze, z_WB_en_WB, z_MEM_R_EN_WB, z_addr_err;
  logic [4:0]  z_dest_WB;
  logic [31:0] z_ALU_result_WB, z_mem_data_WB;

  mem_stage #(.DEPTH(DEPTH), .MEM_BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .WB_en_in(WB_en_in), .MEM_Signal_in(MEM_Signal_in),
    .dest_in(dest_in), .ALU_result_in(ALU_result_in), .reg2_in(reg2_in),
    .freeze(freeze), .WB_en_WB(WB_en_WB), .MEM_R_EN_WB(MEM_R_EN_WB),
    .dest_WB(dest_WB), .ALU_result_WB(ALU_result_WB), .mem_data_WB(mem_data_WB),
    .addr_err(addr_err)
  );

  mem_stage #(.DEPTH(DEPTH), .MEM_BASE(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .WB_en_in(z_WB_en_in), .MEM_Signal_in(z_MEM_Signal_in),
    .dest_in(z_dest_in), .ALU_result_in(z_ALU_result_in), .reg2_in(z_reg2_in),
    .freeze(z_freeze), .WB_en_WB(z_WB_en_WB), .MEM_R_EN_WB(z_MEM_R_EN_WB),
    .dest_WB(z_dest_WB), .ALU_result_WB(z_ALU_result_WB), .mem_data_WB(z_mem_data_WB),
    .addr_err(z_addr_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  logic [31:0] m_mdata = 32'd0;
  bit          m_err = 1'b0;

  typedef struct {
    logic        we;
    logic [1:0]  sig;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] data;
    int          e_frz;
    logic        e_mrd;
    logic [31:0] e_mdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [1:0] sig, input logic [31:0] alu, input logic [31:0] d,
                          output int e_frz, output logic e_mrd);
    logic [31:0] off;
    int          idx;
    bit          bad;
    off = alu - 32'(BASE);
    idx = int'((off >> 2) % 32'(DEPTH));
    bad = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    if (sig != 2'b00)
      bad = (alu < 32'(BASE)) || (alu >= 32'(BASE + 4 * DEPTH)) || (alu[1:0] != 2'b00);
`endif
    e_frz = (sig != 2'b00) ? W : 0;
    e_mrd = (sig == 2'b10);
    if (sig[0] && !bad) begin
      m_mem[idx] = d;
      m_vld[idx] = 1'b1;
    end
    if (sig == 2'b10) m_mdata = bad ? 32'd0 : m_mem[idx];
    if (bad) m_err = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic run_op(input logic we, input logic [1:0] sig, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] d, output int nfrz);
    bit done;
    done = 1'b0;
    nfrz = 0;
    WB_en_in = we; MEM_Signal_in = sig; dest_in = dst; ALU_result_in = alu; reg2_in = d;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (k > 0) check("bubble_wb_en", 32'(WB_en_WB), 32'(0));
      if (!freeze) done = 1'b1;
      else nfrz++;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL op_timeout freeze still high after %0d cycles", nfrz);
    end
    WB_en_in = 1'b0;
    MEM_Signal_in = 2'b00;
  endtask

  task automatic model_checked_op(input string tag, input logic we, input logic [1:0] sig,
                                  input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] d);
    int   e_frz, nfrz;
    logic e_mrd;
    model_op(sig, alu, d, e_frz, e_mrd);
    run_op(we, sig, dst, alu, d, nfrz);
    check({tag, "_freeze_cycles"}, 32'(nfrz), 32'(e_frz));
    check({tag, "_wb_en"}, 32'(WB_en_WB), 32'(we));
    check({tag, "_mem_r_en"}, 32'(MEM_R_EN_WB), 32'(e_mrd));
    check({tag, "_dest"}, 32'(dest_WB), 32'(dst));
    check({tag, "_alu"}, ALU_result_WB, alu);
    check({tag, "_mem_data"}, mem_data_WB, m_mdata);
    check({tag, "_addr_err"}, 32'(addr_err), 32'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nfrz, e_frz;
    logic        e_mrd;
    logic [1:0]  sig;
    int          widx;
    logic [31:0] alu;

    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;

    vecs[0] = '{1'b1, 2'b00, 5'd3,  32'h55,   32'h0,        0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 2'b01, 5'd0,  32'd1028, 32'hDEADBEEF, 2, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 2'b10, 5'd5,  32'd1028, 32'h0,        2, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 2'b11, 5'd6,  32'd1036, 32'd7,        2, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 2'b10, 5'd7,  32'd1036, 32'h0,        2, 1'b1, 32'd7};
    vecs[5] = '{1'b1, 2'b00, 5'd8,  32'h1234, 32'h0,        0, 1'b0, 32'd7};
    vecs[6] = '{1'b0, 2'b01, 5'd9,  32'd1040, 32'h11111111, 2, 1'b0, 32'd7};
    vecs[7] = '{1'b1, 2'b10, 5'd10, 32'd1040, 32'h0,        2, 1'b1, 32'h11111111};
    vecs[8] = '{1'b1, 2'b10, 5'd11, 32'd1028, 32'h0,        2, 1'b1, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    #1;
    check("reset_freeze", 32'(freeze), 32'(0));
    check("reset_wb_en", 32'(WB_en_WB), 32'(0));
    check("reset_mem_r_en", 32'(MEM_R_EN_WB), 32'(0));
    check("reset_dest", 32'(dest_WB), 32'(0));
    check("reset_alu", ALU_result_WB, 32'd0);
    check("reset_mem_data", mem_data_WB, 32'd0);
    check("reset_addr_err", 32'(addr_err), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      model_op(vecs[i].sig, vecs[i].alu, vecs[i].data, e_frz, e_mrd);
      run_op(vecs[i].we, vecs[i].sig, vecs[i].dst, vecs[i].alu, vecs[i].data, nfrz);
      check($sformatf("vec%0d_freeze_cycles", i), 32'(nfrz), 32'(vecs[i].e_frz));
      check($sformatf("vec%0d_wb_en", i), 32'(WB_en_WB), 32'(vecs[i].we));
      check($sformatf("vec%0d_mem_r_en", i), 32'(MEM_R_EN_WB), 32'(vecs[i].e_mrd));
      check($sformatf("vec%0d_dest", i), 32'(dest_WB), 32'(vecs[i].dst));
      check($sformatf("vec%0d_alu", i), ALU_result_WB, vecs[i].alu);
      check($sformatf("vec%0d_mem_data", i), mem_data_WB, vecs[i].e_mdata);
    end

    // Reset in the middle of a store to 1040
    WB_en_in = 1'b1; MEM_Signal_in = 2'b01; dest_in = 5'd12;
    ALU_result_in = 32'd1040; reg2_in = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_freeze_before", 32'(freeze), 32'(1));
    rst = 1'b0;
    #1;
    check("midrst_freeze", 32'(freeze), 32'(0));
    check("midrst_wb_en", 32'(WB_en_WB), 32'(0));
    check("midrst_dest", 32'(dest_WB), 32'(0));
    check("midrst_alu", ALU_result_WB, 32'd0);
    check("midrst_mem_data", mem_data_WB, 32'd0);
    @(posedge clk);
    @(negedge clk);
    WB_en_in = 1'b0; MEM_Signal_in = 2'b00;
    rst = 1'b1;
    m_mdata = 32'd0;
    m_err = 1'b0;
    @(negedge clk);
    model_checked_op("midrst_reload", 1'b1, 2'b10, 5'd13, 32'd1040, 32'h0);
    check("midrst_old_data", mem_data_WB, 32'h11111111);

`ifdef MEM_ADDR_CHECK_EN
    model_checked_op("misaligned_store", 1'b0, 2'b01, 5'd1, 32'd1030, 32'h99);
    check("misaligned_err_set", 32'(addr_err), 32'(1));
    model_checked_op("after_misaligned_load", 1'b1, 2'b10, 5'd2, 32'd1028, 32'h0);
    check("misaligned_mem_unchanged", mem_data_WB, 32'hDEADBEEF);
    check("err_sticky", 32'(addr_err), 32'(1));
    model_checked_op("low_load", 1'b1, 2'b10, 5'd3, 32'd512, 32'h0);
    check("low_load_zero", mem_data_WB, 32'd0);
`else
    model_checked_op("wrap_store", 1'b0, 2'b01, 5'd1, 32'(BASE + 4 * DEPTH), 32'hA5A5A5A5);
    model_checked_op("wrap_load", 1'b1, 2'b10, 5'd2, 32'(BASE), 32'h0);
    check("wrap_data", mem_data_WB, 32'hA5A5A5A5);
`endif

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      sig  = 2'($urandom_range(0, 3));
      widx = int'($urandom_range(0, DEPTH - 1));
      if (sig == 2'b10 && !m_vld[widx]) sig = 2'b01;
      alu = (sig != 2'b00) ? 32'(BASE + 4 * widx) : $urandom;
      model_checked_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sig,
                       5'($urandom_range(0, 31)), alu, $urandom);
    end

    // Zero-wait instance: back-to-back store/load to 1032
    z_WB_en_in = 1'b0; z_MEM_Signal_in = 2'b01; z_dest_in = 5'd1;
    z_ALU_result_in = 32'd1032; z_reg2_in = 32'hCAFEF00D;
    #1;
    check("w0_store_freeze", 32'(z_freeze), 32'(0));
    @(posedge clk);
    @(negedge clk);
    z_WB_en_in = 1'b1; z_MEM_Signal_in = 2'b10; z_dest_in = 5'd4; z_reg2_in = 32'h0;
    #1;
    check("w0_load_freeze", 32'(z_freeze), 32'(0));
    check("w0_store_wb_en", 32'(z_WB_en_WB), 32'(0));
    @(posedge clk);
    @(negedge clk);
    z_WB_en_in = 1'b0; z_MEM_Signal_in = 2'b00;
    check("w0_load_data", z_mem_data_WB, 32'hCAFEF00D);
    check("w0_load_mem_r_en", 32'(z_MEM_R_EN_WB), 32'(1));
    check("w0_load_dest", 32'(z_dest_WB), 32'(4));
    check("w0_addr_err", 32'(z_addr_err), 32'(0));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
